stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Downstream consumer of the Blinker output; core timekeeping and control block of the FPGA stopwatch.
- Divides the board clock to a 100 Hz tick and counts MM:SS.hh in BCD.
- Runs a start/stop/lap/reset FSM from pre-debounced button pulses.
- While paused, gates the display enable with `blink` so the digits flash. Feeds the digit display stage.

Parameters:
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, board clock frequency.
- TICK_HZ, 100, count resolution. DIV = BOARD_CLOCK_FREQUENCY_IN_HZ/TICK_HZ must be an integer ≥ 2.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous active-low reset.
- btn_start_stop  in  1  one-cycle pulse, already debounced.
- btn_lap_reset  in  1  one-cycle pulse, already debounced.
- blink  in  1  square wave from Blinker.
- digits  out  24  BCD {min_t, min_u, sec_t, sec_u, hun_t, hun_u}, 4 bits each.
- display_en  out  1  1 = display lit.
- running  out  1  1 in RUN or LAP.
- overflow  out  1  sticky wrap flag.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, prescaler=0, count=00:00.00, lap latch=0.
  - digits=0, display_en=1, running=0, overflow=0.
- Prescaler:
  - Counts 0..DIV-1 only in RUN/LAP. `tick` asserts for one cycle when prescaler=DIV-1, then wraps to 0.
  - Held (not cleared) in PAUSE, preserving phase. Cleared in IDLE.
- Count chain:
  - On tick: hundredths mod 100; carry into seconds mod 60; carry into minutes mod 60.
  - Each field is 2 BCD digits. Units 0-9; tens 0-9 for hundredths, 0-5 for seconds and minutes.
  - Count updates on the clk edge at which tick is high. Register reflects the new value 1 cycle later.
  - Wrap 59:59.99 -> 00:00.00 sets overflow=1. overflow stays set until IDLE is entered.
- FSM (IDLE, RUN, PAUSE, LAP):
  - IDLE: start_stop -> RUN. lap_reset ignored.
  - RUN: start_stop -> PAUSE. lap_reset -> LAP, capturing the current count into the lap latch in the same cycle.
  - LAP: counting continues. start_stop -> PAUSE (freeze released). lap_reset -> RUN (freeze released).
  - PAUSE: start_stop -> RUN. lap_reset -> IDLE, clearing count, prescaler and overflow.
  - Both pulses in the same cycle: start_stop wins, lap_reset is dropped.
- Outputs (all registered, updated with state):
  - digits = lap latch in LAP; live count in all other states.
  - display_en = blink in PAUSE; 1 in all other states. blink passes combinationally after the state register, with no added latency.
  - running = (state==RUN || state==LAP).
- Tick coinciding with the start_stop that enters PAUSE: the tick is applied.
- Reset mid-operation: immediate return to the reset values, regardless of state.

Optional Feature:
- Macro: STOPWATCH_LAP_COUNT_EN.
- Defined:
  - Adds output lap_count [3:0].
  - Increments on each RUN->LAP transition and saturates at 15.
  - Cleared on reset and on entry to IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package stopwatch_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3.
  - BCD limits: HUN_MOD=100, SEC_MOD=60, MIN_MOD=60.
  - DIGITS_W=24.
- Sub-module bcd_mod_counter (parameter MOD):
  - Ports: clk, rst, en, clr, tens[3:0], units[3:0], carry.
  - carry is combinational: en && value==MOD-1.
  - Instantiated 3 times, chained via carry.

Test Plan (BOARD_CLOCK_FREQUENCY_IN_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset, then start_stop pulse, run 1000 clocks -> digits=00:01.00, running=1, display_en=1.
- Run to 59:59.99, then apply 10 more clocks -> digits=00:00.00, overflow=1. overflow stays 1 through PAUSE and clears after lap_reset in PAUSE.
- In RUN at 00:00.50, pulse lap_reset, run 200 clocks -> digits frozen at 00:00.50. Next lap_reset -> digits=00:00.70.
- In PAUSE at 00:00.05 with blink toggling -> display_en tracks blink, count constant. start_stop -> resumes with the remaining prescaler phase preserved, reaching 00:00.06 exactly (10 - phase) clocks later.
- Simultaneous start_stop and lap_reset in RUN -> PAUSE, no lap capture. Same pair in PAUSE -> RUN, count retained.
- Drop rst to 0 mid-count (async, between edges) -> all outputs return to reset values immediately. With STOPWATCH_LAP_COUNT_EN defined, 17 laps -> lap_count=15.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch core: FSM encoding, BCD field
// limits and the display word width.
package stopwatch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;

    localparam int HUN_MOD  = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int DIGITS_W = 24;

    localparam logic [3:0] LAP_COUNT_MAX = 4'd15;

    // One two-digit BCD field, tens in the upper nibble.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == LAP_COUNT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MOD-1; carry is combinational so the
// next stage advances on the same edge as this one wraps.
module bcd_mod_counter #(
    parameter int MOD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry
);

    localparam logic [3:0] TENS_MAX  = 4'((MOD - 1) / 10);
    localparam logic [3:0] UNITS_MAX = 4'((MOD - 1) % 10);

    logic [3:0] tens_q;
    logic [3:0] units_q;
    logic       at_max;

    assign at_max = (tens_q == TENS_MAX) && (units_q == UNITS_MAX);
    assign carry  = en && at_max;
    assign tens   = tens_q;
    assign units  = units_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else if (clr) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else if (en) begin
            if (at_max) begin
                tens_q  <= 4'd0;
                units_q <= 4'd0;
            end else if (units_q == 4'd9) begin
                tens_q  <= tens_q + 4'd1;
                units_q <= 4'd0;
            end else begin
                units_q <= units_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: 100 Hz prescaler, MM:SS.hh BCD chain and
// start/stop/lap/reset FSM. Optional lap counter under STOPWATCH_LAP_COUNT_EN.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_HZ                     = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_start_stop,
    input  logic                btn_lap_reset,
    input  logic                blink,
    output logic [DIGITS_W-1:0] digits,
    output logic                display_en,
    output logic                running,
`ifdef STOPWATCH_LAP_COUNT_EN
    output logic [3:0]          lap_count,
`endif
    output logic                overflow
);

    localparam int DIV     = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    if (DIV < 2 || DIV * TICK_HZ != BOARD_CLOCK_FREQUENCY_IN_HZ) begin : g_bad_div
        $error("stopwatch_core: clock/tick ratio must be an integer >= 2");
    end

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [PRESC_W-1:0]  prescaler;
    logic                counting;
    logic                tick;
    logic                go_idle;
    logic                lap_capture;
    logic                hun_carry;
    logic                sec_carry;
    logic                wrap;
    bcd2_t               hun;
    bcd2_t               sec;
    bcd2_t               mins;
    logic [DIGITS_W-1:0] live;
    logic [DIGITS_W-1:0] lap_q;
    logic                overflow_q;

    assign counting    = (state == RUN) || (state == LAP);
    assign tick        = counting && (prescaler == PRESC_LAST);
    // start_stop has priority, so lap_reset only acts when it arrives alone.
    assign go_idle     = (state == PAUSE) && !btn_start_stop && btn_lap_reset;
    assign lap_capture = (state == RUN) && !btn_start_stop && btn_lap_reset;

    // NOTE: every path assigns state_nxt first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_start_stop) state_nxt = RUN;
            RUN:     if (btn_start_stop) state_nxt = PAUSE;
                     else if (btn_lap_reset) state_nxt = LAP;
            LAP:     if (btn_start_stop) state_nxt = PAUSE;
                     else if (btn_lap_reset) state_nxt = RUN;
            PAUSE:   if (btn_start_stop) state_nxt = RUN;
                     else if (btn_lap_reset) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Held in PAUSE so a resumed run keeps its sub-tick phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           prescaler <= '0;
        else if (go_idle || state == IDLE)  prescaler <= '0;
        else if (tick)                      prescaler <= '0;
        else if (counting)                  prescaler <= prescaler + PRESC_W'(1);
    end

    bcd_mod_counter #(.MOD(HUN_MOD)) u_hun (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .clr   (go_idle),
        .tens  (hun.tens),
        .units (hun.units),
        .carry (hun_carry)
    );

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (hun_carry),
        .clr   (go_idle),
        .tens  (sec.tens),
        .units (sec.units),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_carry),
        .clr   (go_idle),
        .tens  (mins.tens),
        .units (mins.units),
        .carry (wrap)
    );

    assign live = {mins, sec, hun};

    // NOTE: the lap latch is ordinary flops, not a RAM, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             lap_q <= '0;
        else if (lap_capture) lap_q <= live;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow_q <= 1'b0;
        else if (go_idle) overflow_q <= 1'b0;
        else if (wrap)    overflow_q <= 1'b1;
    end

`ifdef STOPWATCH_LAP_COUNT_EN
    logic [3:0] lap_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             lap_count_q <= 4'd0;
        else if (go_idle)     lap_count_q <= 4'd0;
        else if (lap_capture) lap_count_q <= sat_inc4(lap_count_q);
    end

    assign lap_count = lap_count_q;
`endif

    assign digits     = (state == LAP) ? lap_q : live;
    assign display_en = (state == PAUSE) ? blink : 1'b1;
    assign running    = counting;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core (DIV=10): integer-hundredths model,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_stopwatch_core;

    localparam int DIV  = 10;
    localparam int FULL = 360000;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ss = 1'b0;
    logic        lr = 1'b0;
    logic        blink = 1'b0;
    logic [23:0] digits;
    logic        display_en;
    logic        running;
    logic        overflow;
`ifdef STOPWATCH_LAP_COUNT_EN
    logic [3:0]  lap_count;
`endif

    int checks = 0;
    int errors = 0;

    mstate_t m_state;
    int      m_phase;
    int      m_count;
    int      m_lap;
    int      m_lapcnt;
    bit      m_ovf;

    stopwatch_core #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .TICK_HZ(100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (ss),
        .btn_lap_reset  (lr),
        .blink          (blink),
        .digits         (digits),
        .display_en     (display_en),
        .running        (running),
`ifdef STOPWATCH_LAP_COUNT_EN
        .lap_count      (lap_count),
`endif
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [23:0] to_bcd(input int c);
        int mm;
        int sc;
        int hh;
        mm = c / 6000;
        sc = (c / 100) % 60;
        hh = c % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10), 4'(hh / 10), 4'(hh % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_phase  = 0;
        m_count  = 0;
        m_lap    = 0;
        m_lapcnt = 0;
        m_ovf    = 1'b0;
    endtask

    // One clock edge of the stopwatch as described behaviourally: time in hundredths.
    task automatic model_edge(input bit s, input bit l);
        bit counting;
        bit tick;
        int prev;
        counting = (m_state == M_RUN) || (m_state == M_LAP);
        tick     = counting && (m_phase == DIV - 1);
        prev     = m_count;
        if (counting) m_phase = (m_phase + 1) % DIV;
        if (tick) begin
            if (m_count == FULL - 1) begin
                m_count = 0;
                m_ovf   = 1'b1;
            end else begin
                m_count++;
            end
        end
        case (m_state)
            M_IDLE:  if (s) m_state = M_RUN;
            M_RUN:   if (s) m_state = M_PAUSE;
                     else if (l) begin
                         m_state = M_LAP;
                         m_lap   = prev;
                         if (m_lapcnt < 15) m_lapcnt++;
                     end
            M_LAP:   if (s) m_state = M_PAUSE;
                     else if (l) m_state = M_RUN;
            M_PAUSE: if (s) m_state = M_RUN;
                     else if (l) begin
                         m_state  = M_IDLE;
                         m_count  = 0;
                         m_phase  = 0;
                         m_ovf    = 1'b0;
                         m_lapcnt = 0;
                     end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic compare_model();
        logic [23:0] exp_d;
        exp_d = (m_state == M_LAP) ? to_bcd(m_lap) : to_bcd(m_count);
        check("digits", 32'(digits), 32'(exp_d));
        check("display_en", 32'(display_en), 32'((m_state == M_PAUSE) ? blink : 1'b1));
        check("running", 32'(running), 32'((m_state == M_RUN) || (m_state == M_LAP)));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef STOPWATCH_LAP_COUNT_EN
        check("lap_count", 32'(lap_count), 32'(m_lapcnt));
`endif
    endtask

    task automatic step(input bit s, input bit l);
        @(negedge clk);
        ss = s;
        lr = l;
        if ($urandom_range(0, 2) == 0) blink = ~blink;
        @(posedge clk);
        model_edge(s, l);
        #1;
        ss = 1'b0;
        lr = 1'b0;
        compare_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic to_idle();
        if (m_state == M_RUN || m_state == M_LAP) step(1'b1, 1'b0);
        if (m_state == M_PAUSE) step(1'b0, 1'b1);
    endtask

    // Reset is dropped between edges and the outputs are sampled before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_display_en", 32'(display_en), 32'h1);
        check("rst_running", 32'(running), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        compare_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_display_en", 32'(display_en), 32'h1);
        check("reset_running", 32'(running), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        rst = 1'b1;

        // One second of running.
        step(1'b1, 1'b0);
        run(1000);
        check("one_second", 32'(digits), 32'h000100);
        check("one_second_running", 32'(running), 32'h1);
        check("one_second_display_en", 32'(display_en), 32'h1);

        // Lap freeze and release.
        to_idle();
        check("idle_after_clear", 32'(digits), 32'h0);
        step(1'b1, 1'b0);
        run(500);
        check("lap_pre", 32'(digits), 32'h000050);
        step(1'b0, 1'b1);
        run(200);
        check("lap_frozen", 32'(digits), 32'h000050);
        check("lap_running", 32'(running), 32'h1);
        step(1'b0, 1'b1);
        check("lap_release", 32'(digits), 32'h000070);

        // Pause keeps the prescaler phase (phase 4 after the pausing edge).
        to_idle();
        step(1'b1, 1'b0);
        run(53);
        step(1'b1, 1'b0);
        check("pause_digits", 32'(digits), 32'h000005);
        check("pause_running", 32'(running), 32'h0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            check("pause_blink", 32'(display_en), 32'(blink));
        end
        check("pause_hold", 32'(digits), 32'h000005);
        step(1'b1, 1'b0);
        run(5);
        check("resume_before_tick", 32'(digits), 32'h000005);
        run(1);
        check("resume_tick", 32'(digits), 32'h000006);

        // Both buttons together: start_stop wins.
        step(1'b1, 1'b1);
        check("both_run_to_pause", 32'(running), 32'h0);
        check("both_no_lap", 32'(digits), 32'h000006);
        step(1'b1, 1'b1);
        check("both_pause_to_run", 32'(running), 32'h1);
        check("both_retained", 32'(digits), 32'h000006);

        // Full-range wrap, preloaded while paused.
        step(1'b1, 1'b0);
        force dut.u_min.tens_q  = 4'd5;
        force dut.u_min.units_q = 4'd9;
        force dut.u_sec.tens_q  = 4'd5;
        force dut.u_sec.units_q = 4'd9;
        force dut.u_hun.tens_q  = 4'd9;
        force dut.u_hun.units_q = 4'd9;
        m_count = FULL - 1;
        step(1'b0, 1'b0);
        release dut.u_min.tens_q;
        release dut.u_min.units_q;
        release dut.u_sec.tens_q;
        release dut.u_sec.units_q;
        release dut.u_hun.tens_q;
        release dut.u_hun.units_q;
        check("preload", 32'(digits), 32'h595999);
        step(1'b1, 1'b0);
        for (int i = 0; i < 20 && !m_ovf; i++) step(1'b0, 1'b0);
        check("wrap_digits", 32'(digits), 32'h000000);
        check("wrap_overflow", 32'(overflow), 32'h1);
        run(30);
        check("overflow_sticky_run", 32'(overflow), 32'h1);
        step(1'b1, 1'b0);
        check("overflow_sticky_pause", 32'(overflow), 32'h1);
        step(1'b0, 1'b1);
        check("overflow_cleared", 32'(overflow), 32'h0);
        check("idle_digits", 32'(digits), 32'h0);

        // Seventeen laps saturate the lap counter.
        step(1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1);
            run(3);
            step(1'b0, 1'b1);
        end
`ifdef STOPWATCH_LAP_COUNT_EN
        check("lap_count_sat", 32'(lap_count), 32'd15);
`endif

        // Asynchronous reset mid-count.
        run(37);
        async_reset();

        // Randomized button traffic.
        for (int i = 0; i < 20000; i++) begin
            bit s;
            bit l;
            s = ($urandom_range(0, 99) < 3);
            l = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 5999) == 0) async_reset();
            else step(s, l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
